// File: rtl/ac_search_ctrl.sv
// Aho-Corasick search sequencer: walks goto/failure tables for a 4-bit char stream.
// Latency: direct hit emits 3 cycles after accept, +4 cycles per failure hop.
// Backpressure: CHAR_READY only in IDLE (gated by EN); one character in flight.
// Optional feature macro: AC_HOP_STATS_EN adds the 16-bit saturating HOP_TOTAL counter.
module ac_search_ctrl #(
    parameter logic [7:0] FAIL_CODE = 8'hFF,
    parameter logic [7:0] MAX_HOPS  = 8'd32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        CLR,
    input  logic        CHAR_VALID,
    input  logic [3:0]  CHAR_IN,
    output logic        CHAR_READY,
    output logic        GOTO_RD,
    output logic [11:0] GOTO_ADDR,
    input  logic [7:0]  GOTO_DATA,
    output logic        FAIL_RD,
    output logic [7:0]  FAIL_ADDR,
    input  logic [7:0]  FAIL_DATA,
    output logic        OUT_VALID,
    output logic [7:0]  OUT_STATE,
    output logic        ERR
`ifdef AC_HOP_STATS_EN
    ,
    output logic [15:0] HOP_TOTAL
`endif
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GOTO_ISSUE = 3'd1,
        GOTO_CHECK = 3'd2,
        FAIL_ISSUE = 3'd3,
        FAIL_CHECK = 3'd4,
        EMIT       = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cur_state_q, cur_state_d;
    logic [3:0]  char_q, char_d;
    logic [7:0]  hop_cnt_q, hop_cnt_d;
    logic        err_q, err_d;
    logic        goto_rd_q, goto_rd_d;
    logic [11:0] goto_addr_q, goto_addr_d;
    logic        fail_rd_q, fail_rd_d;
    logic [7:0]  fail_addr_q, fail_addr_d;
    logic        out_vld_q, out_vld_d;
    logic [7:0]  out_state_q, out_state_d;

    // Ready is the only combinational output; held low while reset is asserted.
    assign CHAR_READY = EN && RST && (state_q == IDLE);

    assign GOTO_RD   = goto_rd_q;
    assign GOTO_ADDR = goto_addr_q;
    assign FAIL_RD   = fail_rd_q;
    assign FAIL_ADDR = fail_addr_q;
    assign OUT_VALID = out_vld_q;
    assign OUT_STATE = out_state_q;
    assign ERR       = err_q;

    // Next-state walk, then registered strobes decoded from the state being entered.
    always_comb begin
        state_d     = state_q;
        cur_state_d = cur_state_q;
        char_d      = char_q;
        hop_cnt_d   = hop_cnt_q;
        err_d       = err_q;
        goto_rd_d   = 1'b0;
        goto_addr_d = goto_addr_q;
        fail_rd_d   = 1'b0;
        fail_addr_d = fail_addr_q;
        out_vld_d   = 1'b0;
        out_state_d = out_state_q;

        case (state_q)
            IDLE: begin
                if (CHAR_VALID && CHAR_READY) begin
                    char_d    = CHAR_IN;
                    hop_cnt_d = 8'd0;
                    state_d   = GOTO_ISSUE;
                end
            end
            GOTO_ISSUE: state_d = GOTO_CHECK;
            GOTO_CHECK: begin
                if (GOTO_DATA != FAIL_CODE) begin
                    cur_state_d = GOTO_DATA;
                    state_d     = EMIT;
                end else if (cur_state_q == 8'd0) begin
                    // root has an implicit self-loop on every miss
                    state_d = EMIT;
                end else begin
                    state_d = FAIL_ISSUE;
                end
            end
            FAIL_ISSUE: begin
                if (hop_cnt_q == MAX_HOPS) begin
                    err_d       = 1'b1;
                    cur_state_d = 8'd0;
                    state_d     = EMIT;
                end else begin
                    hop_cnt_d = hop_cnt_q + 8'd1;
                    state_d   = FAIL_CHECK;
                end
            end
            FAIL_CHECK: begin
                cur_state_d = FAIL_DATA;
                state_d     = GOTO_ISSUE;
            end
            EMIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // restart wins over the walk; the sticky error is left untouched
        if (CLR) begin
            state_d     = IDLE;
            cur_state_d = 8'd0;
            err_d       = err_q;
        end

        case (state_d)
            GOTO_ISSUE: begin
                goto_rd_d   = 1'b1;
                goto_addr_d = {cur_state_d, char_d};
            end
            FAIL_ISSUE: begin
                // on the aborting visit no failure read is launched
                if (hop_cnt_d != MAX_HOPS) begin
                    fail_rd_d   = 1'b1;
                    fail_addr_d = cur_state_d;
                end
            end
            EMIT: begin
                out_vld_d   = 1'b1;
                out_state_d = cur_state_d;
            end
            default: ;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            cur_state_q <= 8'd0;
            char_q      <= 4'd0;
            hop_cnt_q   <= 8'd0;
            err_q       <= 1'b0;
            goto_rd_q   <= 1'b0;
            goto_addr_q <= 12'd0;
            fail_rd_q   <= 1'b0;
            fail_addr_q <= 8'd0;
            out_vld_q   <= 1'b0;
            out_state_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cur_state_q <= cur_state_d;
            char_q      <= char_d;
            hop_cnt_q   <= hop_cnt_d;
            err_q       <= err_d;
            goto_rd_q   <= goto_rd_d;
            goto_addr_q <= goto_addr_d;
            fail_rd_q   <= fail_rd_d;
            fail_addr_q <= fail_addr_d;
            out_vld_q   <= out_vld_d;
            out_state_q <= out_state_d;
        end
    end

`ifdef AC_HOP_STATS_EN
    logic [15:0] hop_total_q;

    assign HOP_TOTAL = hop_total_q;

    // Saturating count of failure reads; CLR does not touch it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hop_total_q <= 16'd0;
        end else if (fail_rd_d && (hop_total_q != 16'hFFFF)) begin
            hop_total_q <= hop_total_q + 16'd1;
        end
    end
`endif

endmodule
